// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port pair between the gradient and gamma engines, gated by a
// WAIT/RUN/DRAIN frame sequencer. All outputs are registered (1-cycle latency).
module bram_port_arbiter #(
    parameter int     ADDR_W     = 17,
    parameter int     BYTES      = 4,
    parameter int     OUT_W      = 32,
    parameter int     NUM_DEF    = 2,
    parameter longint ADDR_LIMIT = (longint'(1) << ADDR_W) - 1,
    localparam int    SEL_W      = (NUM_DEF > 1) ? $clog2(NUM_DEF) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               new_frame,
    input  logic                      frame_done,
    input  logic                      grad_busy,
    input  logic                      grad_wea,
    input  logic [ADDR_W-1:0]         grad_addr,
    input  logic [ADDR_W-1:0]         gamma_addr_ref,
    input  logic [NUM_DEF*ADDR_W-1:0] gamma_addr_def,
    input  logic [SEL_W-1:0]          def_sel,
    output logic [BYTES-1:0]          out_wea,
    output logic [OUT_W-1:0]          out_addr_ref,
    output logic [OUT_W-1:0]          out_addr_def,
    output logic                      waiting,
    output logic [15:0]               frame_count,
    output logic                      addr_err
);

    localparam int SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int SLOTS = 1 << SEL_W;
    localparam int LIM_W = ADDR_W + 1;
    localparam logic [LIM_W-1:0] LIMIT = LIM_W'(ADDR_LIMIT);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t             state, state_nxt;
    logic [BYTES-1:0]   wea_nxt;
    logic [OUT_W-1:0]   ref_nxt, def_nxt;
    logic               waiting_nxt, err_nxt, update;
    logic [15:0]        count_nxt;

    logic               frame_ok;
    logic [ADDR_W-1:0]  def_words [SLOTS];
    logic [ADDR_W-1:0]  def_word;
    logic               def_sel_ok, grad_over, ref_over, def_bad;

    // Pad the channel table to a power of two so an out-of-range def_sel
    // reads a defined value; def_sel_ok still flags it as an error.
    for (genvar k = 0; k < SLOTS; k++) begin : g_def
        if (k < NUM_DEF) begin : g_used
            assign def_words[k] = gamma_addr_def[k*ADDR_W +: ADDR_W];
        end else begin : g_pad
            assign def_words[k] = '0;
        end
    end

    function automatic logic [OUT_W-1:0] scale(input logic [ADDR_W-1:0] word);
        return OUT_W'(word) << SHIFT;
    endfunction

    assign frame_ok   = (new_frame == 32'd1);
    assign def_word   = def_words[def_sel];
    assign def_sel_ok = (int'(def_sel) < NUM_DEF);
    assign grad_over  = ({1'b0, grad_addr} > LIMIT);
    assign ref_over   = ({1'b0, gamma_addr_ref} > LIMIT);
    assign def_bad    = !def_sel_ok || ({1'b0, def_word} > LIMIT);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a signal unassigned and infer a latch.
        state_nxt   = state;
        wea_nxt     = '0;
        waiting_nxt = 1'b1;
        ref_nxt     = out_addr_ref;
        def_nxt     = out_addr_def;
        count_nxt   = frame_count;
        err_nxt     = addr_err;
        update      = 1'b0;

        case (state)
            ST_WAIT: begin
                if (frame_ok) begin
                    update    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                update = frame_ok;
                if (frame_done) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                count_nxt = frame_count + 16'd1;
                state_nxt = ST_WAIT;
            end
            default: state_nxt = ST_WAIT;
        endcase

        // Exactly one owner per cycle; an illegal address holds only the
        // output it would have driven and suppresses the write.
        if (update) begin
            waiting_nxt = 1'b0;
            if (grad_busy) begin
                if (grad_over) begin
                    err_nxt = 1'b1;
                end else begin
                    ref_nxt = scale(grad_addr);
                    wea_nxt = {BYTES{grad_wea}};
                end
            end else begin
                if (ref_over) err_nxt = 1'b1;
                else          ref_nxt = scale(gamma_addr_ref);
                if (def_bad)  err_nxt = 1'b1;
                else          def_nxt = scale(def_word);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_WAIT;
            out_wea      <= '0;
            out_addr_ref <= '0;
            out_addr_def <= '0;
            waiting      <= 1'b1;
            frame_count  <= '0;
            addr_err     <= 1'b0;
        end else begin
            state        <= state_nxt;
            out_wea      <= wea_nxt;
            out_addr_ref <= ref_nxt;
            out_addr_def <= def_nxt;
            waiting      <= waiting_nxt;
            frame_count  <= count_nxt;
            addr_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: a behavioural model pushes the
// expected registered outputs each cycle; each test pops and compares inline.
module tb_bram_port_arbiter;

    localparam int ADDR_W = 17;
    localparam int LIMIT  = 255;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] new_frame = '0;
    logic        frame_done = 1'b0;
    logic        grad_busy = 1'b0;
    logic        grad_wea = 1'b0;
    logic [ADDR_W-1:0]   grad_addr = '0;
    logic [ADDR_W-1:0]   gamma_addr_ref = '0;
    logic [2*ADDR_W-1:0] gamma_addr_def = '0;
    logic [0:0]  def_sel = '0;
    logic [3:0]  out_wea;
    logic [31:0] out_addr_ref, out_addr_def;
    logic        waiting;
    logic [15:0] frame_count;
    logic        addr_err;

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .BYTES(4), .OUT_W(32), .NUM_DEF(2), .ADDR_LIMIT(LIMIT)
    ) dut (
        .clock(clock), .reset(reset), .new_frame(new_frame), .frame_done(frame_done),
        .grad_busy(grad_busy), .grad_wea(grad_wea), .grad_addr(grad_addr),
        .gamma_addr_ref(gamma_addr_ref), .gamma_addr_def(gamma_addr_def),
        .def_sel(def_sel), .out_wea(out_wea), .out_addr_ref(out_addr_ref),
        .out_addr_def(out_addr_def), .waiting(waiting), .frame_count(frame_count),
        .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  wea;
        logic [31:0] addr_ref;
        logic [31:0] addr_def;
        logic        waiting;
        logic [15:0] cnt;
        logic        err;
    } obs_t;

    typedef enum {M_WAIT, M_RUN, M_DRAIN} mstate_t;

    localparam obs_t RESET_OBS = '{wea: 4'h0, addr_ref: 32'h0, addr_def: 32'h0,
                                   waiting: 1'b1, cnt: 16'h0, err: 1'b0};

    obs_t    sb[$];
    obs_t    m;
    mstate_t ms;
    obs_t    exp_o, act_o;
    int      total = 0;
    int      passed = 0;

    function automatic obs_t observe();
        obs_t o;
        o.wea = out_wea; o.addr_ref = out_addr_ref; o.addr_def = out_addr_def;
        o.waiting = waiting; o.cnt = frame_count; o.err = addr_err;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("wea=%h ref=%h def=%h wait=%b cnt=%h err=%b",
                         o.wea, o.addr_ref, o.addr_def, o.waiting, o.cnt, o.err);
    endfunction

    task automatic model_reset();
        m  = RESET_OBS;
        ms = M_WAIT;
        sb.delete();
    endtask

    // Effect of one accepted transfer cycle on the expected outputs.
    task automatic model_issue(inout obs_t e);
        logic [ADDR_W-1:0] ref_word, def_word;
        e.waiting = 1'b0;
        if (grad_busy) begin
            if (grad_addr > LIMIT) e.err = 1'b1;
            else begin
                e.addr_ref = 32'(grad_addr) * 4;
                e.wea      = grad_wea ? 4'b1111 : 4'b0000;
            end
        end else begin
            ref_word = gamma_addr_ref;
            def_word = def_sel[0] ? gamma_addr_def[2*ADDR_W-1:ADDR_W] : gamma_addr_def[ADDR_W-1:0];
            if (ref_word > LIMIT) e.err = 1'b1; else e.addr_ref = 32'(ref_word) * 4;
            if (def_word > LIMIT) e.err = 1'b1; else e.addr_def = 32'(def_word) * 4;
        end
    endtask

    task automatic model_step();
        obs_t e;
        e = m;
        e.wea = 4'h0;
        e.waiting = 1'b1;
        case (ms)
            M_WAIT: if (new_frame == 32'd1) begin model_issue(e); ms = M_RUN; end
            M_RUN: begin
                if (new_frame == 32'd1) model_issue(e);
                if (frame_done) ms = M_DRAIN;
            end
            default: begin e.cnt = e.cnt + 16'd1; ms = M_WAIT; end
        endcase
        m = e;
        sb.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        act_o = observe(); total++;
        if (act_o !== RESET_OBS) $display("FAIL reset_state: got %s want %s", fmt(act_o), fmt(RESET_OBS));
        else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        tick();
        exp_o = sb.pop_front(); act_o = observe(); total++;
        if (act_o !== exp_o) $display("FAIL idle_wait: got %s want %s", fmt(act_o), fmt(exp_o));
        else passed++;
    endtask

    task automatic test_grad_write();
        new_frame = 32'd1; grad_busy = 1'b1; grad_wea = 1'b1; grad_addr = 17'h00010;
        tick();
        exp_o = sb.pop_front(); act_o = observe(); total++;
        if (act_o !== exp_o) $display("FAIL grad_write: got %s want %s", fmt(act_o), fmt(exp_o));
        else passed++;
        total++;
        if (out_addr_ref !== 32'h40 || out_wea !== 4'b1111 || waiting !== 1'b0)
            $display("FAIL grad_write_direct: got ref=%h wea=%b wait=%b want ref=40 wea=1111 wait=0",
                     out_addr_ref, out_wea, waiting);
        else passed++;
    endtask

    task automatic test_gamma_read();
        grad_busy = 1'b0; grad_wea = 1'b1; gamma_addr_ref = 17'd5;
        gamma_addr_def = {17'd9, 17'd7}; def_sel = 1'b1;
        tick();
        exp_o = sb.pop_front(); act_o = observe(); total++;
        if (act_o !== exp_o) $display("FAIL gamma_read: got %s want %s", fmt(act_o), fmt(exp_o));
        else passed++;
        total++;
        if (out_addr_ref !== 32'd20 || out_addr_def !== 32'd36 || out_wea !== 4'b0000)
            $display("FAIL gamma_read_direct: got ref=%0d def=%0d wea=%b want ref=20 def=36 wea=0000",
                     out_addr_ref, out_addr_def, out_wea);
        else passed++;
        def_sel = 1'b0;
        tick();
        exp_o = sb.pop_front(); act_o = observe(); total++;
        if (act_o !== exp_o) $display("FAIL gamma_sel0: got %s want %s", fmt(act_o), fmt(exp_o));
        else passed++;
    endtask

    task automatic test_owner_toggle();
        for (int i = 0; i < 24; i++) begin
            grad_busy      = 1'($urandom_range(0, 1));
            grad_wea       = 1'($urandom_range(0, 1));
            grad_addr      = 17'($urandom_range(0, LIMIT));
            gamma_addr_ref = 17'($urandom_range(0, LIMIT));
            gamma_addr_def = {17'($urandom_range(0, LIMIT)), 17'($urandom_range(0, LIMIT))};
            def_sel        = 1'($urandom_range(0, 1));
            tick();
            exp_o = sb.pop_front(); act_o = observe(); total++;
            if (act_o !== exp_o) $display("FAIL owner_toggle[%0d]: got %s want %s", i, fmt(act_o), fmt(exp_o));
            else passed++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_ref;
        held_ref = out_addr_ref;
        new_frame = 32'd0; grad_busy = 1'b1; grad_wea = 1'b1;
        for (int i = 0; i < 3; i++) begin
            grad_addr = 17'(8'h20 + i);
            if (i == 1) new_frame = 32'd3;
            tick();
            exp_o = sb.pop_front(); act_o = observe(); total++;
            if (act_o !== exp_o || out_addr_ref !== held_ref || waiting !== 1'b1)
                $display("FAIL stall[%0d]: got %s want %s", i, fmt(act_o), fmt(exp_o));
            else passed++;
        end
        new_frame = 32'd1; grad_addr = 17'h33;
        tick();
        exp_o = sb.pop_front(); act_o = observe(); total++;
        if (act_o !== exp_o || out_addr_ref !== 32'hCC || waiting !== 1'b0)
            $display("FAIL stall_resume: got %s want %s", fmt(act_o), fmt(exp_o));
        else passed++;
    endtask

    task automatic test_addr_err();
        logic [31:0] held_ref;
        held_ref = out_addr_ref;
        grad_busy = 1'b1; grad_wea = 1'b1; grad_addr = 17'h100;
        tick();
        exp_o = sb.pop_front(); act_o = observe(); total++;
        if (act_o !== exp_o || out_wea !== 4'b0000 || addr_err !== 1'b1 || out_addr_ref !== held_ref)
            $display("FAIL addr_err_set: got %s want %s", fmt(act_o), fmt(exp_o));
        else passed++;
        grad_addr = 17'h0FF;
        for (int i = 0; i < 3; i++) begin
            grad_busy = (i != 1);
            gamma_addr_ref = 17'h12; gamma_addr_def = {17'h34, 17'h56};
            tick();
            exp_o = sb.pop_front(); act_o = observe(); total++;
            if (act_o !== exp_o || addr_err !== 1'b1)
                $display("FAIL addr_err_sticky[%0d]: got %s want %s", i, fmt(act_o), fmt(exp_o));
            else passed++;
        end
    endtask

    task automatic test_frame_done();
        grad_busy = 1'b1; grad_wea = 1'b1; grad_addr = 17'h44; frame_done = 1'b1;
        tick();
        frame_done = 1'b0; new_frame = 32'd0;
        exp_o = sb.pop_front(); act_o = observe(); total++;
        if (act_o !== exp_o || out_wea !== 4'b1111 || out_addr_ref !== 32'h110)
            $display("FAIL done_write: got %s want %s", fmt(act_o), fmt(exp_o));
        else passed++;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            exp_o = sb.pop_front(); act_o = observe(); total++;
            if (act_o !== exp_o || out_wea !== 4'b0000 || waiting !== 1'b1 || frame_count !== 16'd1)
                $display("FAIL drain_wait[%0d]: got %s want %s", i, fmt(act_o), fmt(exp_o));
            else passed++;
        end
    endtask

    task automatic test_reset_mid_run();
        new_frame = 32'd1;
        tick();
        exp_o = sb.pop_front(); act_o = observe(); total++;
        if (act_o !== exp_o) $display("FAIL pre_abort: got %s want %s", fmt(act_o), fmt(exp_o));
        else passed++;
        #2 reset = 1'b1;
        #1;
        model_reset();
        act_o = observe(); total++;
        if (act_o !== RESET_OBS) $display("FAIL abort_reset: got %s want %s", fmt(act_o), fmt(RESET_OBS));
        else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        // frame_done on the first edge must be ignored because that edge is in WAIT
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0; new_frame = 32'd0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            exp_o = sb.pop_front(); act_o = observe(); total++;
            if (act_o !== exp_o || frame_count !== 16'd0)
                $display("FAIL post_abort[%0d]: got %s want %s", i, fmt(act_o), fmt(exp_o));
            else passed++;
        end
    endtask

    task automatic test_wrap();
        int bad;
        #2 reset = 1'b1;
        #1 model_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        grad_busy = 1'b1; grad_wea = 1'b1; grad_addr = 17'h7;
        bad = 0;
        for (int f = 0; f < 65536; f++) begin
            new_frame = 32'd1; frame_done = 1'b0;
            tick();
            exp_o = sb.pop_front(); act_o = observe(); total++;
            if (act_o !== exp_o) begin
                if (bad < 5) $display("FAIL wrap_start[%0d]: got %s want %s", f, fmt(act_o), fmt(exp_o));
                bad++;
            end else passed++;
            frame_done = 1'b1;
            tick();
            exp_o = sb.pop_front(); act_o = observe(); total++;
            if (act_o !== exp_o) begin
                if (bad < 5) $display("FAIL wrap_done[%0d]: got %s want %s", f, fmt(act_o), fmt(exp_o));
                bad++;
            end else passed++;
            frame_done = 1'b0; new_frame = 32'd0;
            tick();
            exp_o = sb.pop_front(); act_o = observe(); total++;
            if (act_o !== exp_o) begin
                if (bad < 5) $display("FAIL wrap_drain[%0d]: got %s want %s", f, fmt(act_o), fmt(exp_o));
                bad++;
            end else passed++;
            if (f == 65534) begin
                total++;
                if (frame_count !== 16'hFFFF) $display("FAIL count_ffff: got %h want ffff", frame_count);
                else passed++;
            end
        end
        total++;
        if (frame_count !== 16'h0000) $display("FAIL count_wrap: got %h want 0000", frame_count);
        else passed++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_grad_write();
        test_gamma_read();
        test_owner_toggle();
        test_stall();
        test_addr_err();
        test_frame_done();
        test_reset_mid_run();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
